counter_ctrl: RTL and testbench

//   Run/pause/stop controller for the 4-bit up counter in Counter4bit_Up.

---
 rtl/counter_pkg.sv | 14 +
 rtl/tick_gen.sv | 37 +++
 rtl/counter_ctrl.sv | 109 ++++++++++
 tb/tb_counter_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the run/pause/stop counter controller.
package counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DIV_1HZ   = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle count-enable tick every DIV enabled clocks.
// Holds its value while disabled so a paused fraction is preserved.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = en_i && (presc_q == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/stop sequencer for an up counter with load, terminal count and
// optional auto-reload; all outputs registered.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DIV_1HZ
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             clear_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] term_val_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic [1:0]       state_o,
    output logic             running_o,
    output logic             done_o,
    output logic             tc_pulse_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             running_q, done_q;
    logic             presc_clr;
    logic             tick;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (state_q == ST_RUN),
        .clr_i   (presc_clr),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;
        presc_clr = 1'b0;
        if (clear_i) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            presc_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_en_i) begin
                        count_d  = load_val_i;
                        reload_d = load_val_i;
                    end else if (start_i) begin
                        state_d   = ST_RUN;
                        presc_clr = 1'b1;
                        if (state_q == ST_DONE) count_d = reload_q;
                    end
                end
                ST_RUN: begin
                    // pause swallows a coincident tick; the prescaler still wraps
                    if (pause_i) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (count_q == term_val_i) begin
                            tc_d = 1'b1;
                            if (auto_reload_i) count_d = reload_q;
                            else               state_d = ST_DONE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_i) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tc_q      <= tc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign count_o    = count_q;
    assign state_o    = state_q;
    assign running_o  = running_q;
    assign done_o     = done_q;
    assign tc_pulse_o = tc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed plus randomized bench for counter_ctrl against a cycle-level
// behavioural model built from integer arithmetic.
module tb_counter_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0, pause_i = 1'b0, clear_i = 1'b0, load_en_i = 1'b0;
    logic [WIDTH-1:0] load_val_i = '0, term_val_i = '0;
    logic             auto_reload_i = 1'b0;
    logic [WIDTH-1:0] count_o;
    logic [1:0]       state_o;
    logic             running_o, done_o, tc_pulse_o;

    int checks = 0;
    int errors = 0;

    // model: states as the published encoding values 0..3, elapsed = cycles into tick period
    int m_st = 0, m_cnt = 0, m_rel = 0, m_elapsed = 0, m_tc = 0;

    counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .pause_i       (pause_i),
        .clear_i       (clear_i),
        .load_en_i     (load_en_i),
        .load_val_i    (load_val_i),
        .term_val_i    (term_val_i),
        .auto_reload_i (auto_reload_i),
        .count_o       (count_o),
        .state_o       (state_o),
        .running_o     (running_o),
        .done_o        (done_o),
        .tc_pulse_o    (tc_pulse_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tick;
        tick = (m_st == 1) && (m_elapsed == DIV - 1);
        m_tc = 0;
        if (reset_i) begin
            m_st = 0; m_cnt = 0; m_rel = 0; m_elapsed = 0;
        end else begin
            if (m_st == 1) m_elapsed = (m_elapsed + 1) % DIV;
            if (clear_i) begin
                m_st = 0; m_cnt = 0; m_elapsed = 0;
            end else if (m_st == 0 || m_st == 3) begin
                if (load_en_i) begin
                    m_cnt = int'(load_val_i); m_rel = int'(load_val_i);
                end else if (start_i) begin
                    if (m_st == 3) m_cnt = m_rel;
                    m_st = 1; m_elapsed = 0;
                end
            end else if (m_st == 1) begin
                if (pause_i) m_st = 2;
                else if (tick) begin
                    if (m_cnt == int'(term_val_i)) begin
                        m_tc = 1;
                        if (auto_reload_i) m_cnt = m_rel;
                        else               m_st = 3;
                    end else begin
                        m_cnt = (m_cnt + 1) % MODV;
                    end
                end
            end else if (start_i) begin
                m_st = 1;
            end
        end
    endtask

    // one clock: model sees the driven inputs, DUT samples them, outputs compared 1 time unit later
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("state",   32'(state_o),    32'(m_st));
        chk("count",   32'(count_o),    32'(m_cnt));
        chk("running", 32'(running_o),  32'(m_st == 1));
        chk("done",    32'(done_o),     32'(m_st == 3));
        chk("tc",      32'(tc_pulse_o), 32'(m_tc));
        reset_i = 0; start_i = 0; pause_i = 0; clear_i = 0; load_en_i = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // reset
        reset_i = 1; cyc();
        reset_i = 1; cyc();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_flags", {29'd0, running_o, done_o, tc_pulse_o}, 32'd0);

        // basic counting at DIV spacing
        term_val_i = 4'd15;
        start_i = 1; cyc();
        run(3);
        chk("basic_pre1", 32'(count_o), 32'd0);
        run(1);
        chk("basic_1", 32'(count_o), 32'd1);
        chk("basic_run", 32'(running_o), 32'd1);
        run(4); chk("basic_2", 32'(count_o), 32'd2);
        run(4); chk("basic_3", 32'(count_o), 32'd3);

        // load 13, terminal 15, stop at terminal
        clear_i = 1; cyc();
        load_val_i = 4'd13; load_en_i = 1; cyc();
        term_val_i = 4'd15; auto_reload_i = 0;
        start_i = 1; cyc();
        run(4); chk("stop_14", 32'(count_o), 32'd14);
        run(4); chk("stop_15", 32'(count_o), 32'd15);
        run(4);
        chk("stop_tc", 32'(tc_pulse_o), 32'd1);
        chk("stop_state", 32'(state_o), 32'd3);
        chk("stop_done", 32'(done_o), 32'd1);
        run(1);
        chk("stop_tc_end", 32'(tc_pulse_o), 32'd0);
        chk("stop_hold", 32'(count_o), 32'd15);

        // auto-reload 2..4 from DONE
        load_val_i = 4'd2; load_en_i = 1; cyc();
        term_val_i = 4'd4; auto_reload_i = 1;
        start_i = 1; cyc();
        chk("ar_start", 32'(count_o), 32'd2);
        run(4); chk("ar_3", 32'(count_o), 32'd3);
        run(4); chk("ar_4", 32'(count_o), 32'd4);
        run(4);
        chk("ar_reload", 32'(count_o), 32'd2);
        chk("ar_tc", 32'(tc_pulse_o), 32'd1);
        chk("ar_state", 32'(state_o), 32'd1);
        run(4); chk("ar_3b", 32'(count_o), 32'd3);

        // wrap-around: 14 -> 15 -> 0 -> 1 -> DONE
        clear_i = 1; cyc();
        load_val_i = 4'd14; load_en_i = 1; cyc();
        term_val_i = 4'd1; auto_reload_i = 0;
        start_i = 1; cyc();
        run(4); chk("wrap_15", 32'(count_o), 32'd15);
        run(4); chk("wrap_0", 32'(count_o), 32'd0);
        run(4); chk("wrap_1", 32'(count_o), 32'd1);
        run(4);
        chk("wrap_done", 32'(state_o), 32'd3);
        chk("wrap_tc", 32'(tc_pulse_o), 32'd1);

        // pause two cycles into a period; fraction preserved
        clear_i = 1; cyc();
        load_val_i = 4'd0; load_en_i = 1; cyc();
        term_val_i = 4'd15; auto_reload_i = 0;
        start_i = 1; cyc();
        run(4); chk("pz_1", 32'(count_o), 32'd1);
        run(1);
        pause_i = 1; cyc();
        chk("pz_state", 32'(state_o), 32'd2);
        run(20);
        chk("pz_frozen", 32'(count_o), 32'd1);
        start_i = 1; cyc();
        run(1); chk("pz_not_yet", 32'(count_o), 32'd1);
        run(1); chk("pz_resume", 32'(count_o), 32'd2);

        // load ignored in RUN, clear keeps reload_reg, restart from DONE
        clear_i = 1; cyc();
        load_val_i = 4'd5; load_en_i = 1; cyc();
        term_val_i = 4'd6;
        start_i = 1; cyc();
        run(2);
        load_val_i = 4'd9; load_en_i = 1; cyc();
        chk("ld_ignored", 32'(count_o), 32'd5);
        clear_i = 1; cyc();
        chk("clr_state", 32'(state_o), 32'd0);
        chk("clr_count", 32'(count_o), 32'd0);
        term_val_i = 4'd0;
        start_i = 1; cyc();
        run(4);
        chk("rs_done", 32'(state_o), 32'd3);
        start_i = 1; cyc();
        chk("rs_reload", 32'(count_o), 32'd5);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            start_i   = (r < 10);
            pause_i   = (r >= 10 && r < 14);
            clear_i   = (r >= 14 && r < 16);
            load_en_i = (r >= 16 && r < 20);
            reset_i   = (r == 20);
            load_val_i = WIDTH'($urandom_range(0, MODV - 1));
            if ($urandom_range(0, 31) == 0) term_val_i = WIDTH'($urandom_range(0, MODV - 1));
            if ($urandom_range(0, 15) == 0) auto_reload_i = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
